// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one memory request at a time,
// and absorbs memory latency, hazard stalls and redirects. Optional macro: IF_NOP_BUBBLE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_addr,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        mem_stall_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q, addr_q, hold_q;
    logic        kill_q;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic [31:0] inst_cur;

    assign pc_plus4     = pc_q + 32'd4;
    assign im_req_valid = (state == REQ);
    assign im_addr      = addr_q;
    assign pc_o         = pc_q;
    assign pc4_o        = pc_plus4;

    // A killed response never reaches the pipeline register.
    assign inst_valid  = ((state == WAIT) && im_rsp_valid && !kill_q) || (state == HOLD);
    assign inst_cur    = (state == HOLD) ? hold_q : im_rsp_data;
    assign mem_stall_o = !inst_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
            kill_q <= 1'b0;
            hold_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect) begin
                        pc_q   <= redirect_pc;
                        addr_q <= redirect_pc;
                    end else begin
                        addr_q <= pc_q;
                    end
                end
                REQ: begin
                    // The in-flight address stays put; its response is dropped via kill_q.
                    if (redirect) begin
                        pc_q   <= redirect_pc;
                        kill_q <= 1'b1;
                    end
                    if (im_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (im_rsp_valid) begin
                        kill_q <= 1'b0;
                        state  <= REQ;
                        if (redirect) begin
                            pc_q   <= redirect_pc;
                            addr_q <= redirect_pc;
                        end else if (kill_q) begin
                            addr_q <= pc_q;
                        end else if (!hazard_stall) begin
                            pc_q   <= pc_plus4;
                            addr_q <= pc_plus4;
                        end else begin
                            hold_q <= im_rsp_data;
                            state  <= HOLD;
                        end
                    end else if (redirect) begin
                        pc_q   <= redirect_pc;
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q   <= redirect_pc;
                        addr_q <= redirect_pc;
                        state  <= REQ;
                    end else if (!hazard_stall) begin
                        pc_q   <= pc_plus4;
                        addr_q <= pc_plus4;
                        state  <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_NOP_BUBBLE_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
    assign inst_o = inst_valid ? inst_cur : NOP;
`else
    logic [31:0] last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             last_q <= 32'h0;
        else if (inst_valid) last_q <= inst_cur;
    end
    assign inst_o = inst_valid ? inst_cur : last_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a memory responder model, directed stimulus pushing
// expected presentations, and a monitor comparing every presented/bubble cycle.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic [31:0] pc_o, pc4_o, inst_o;
    logic        mem_stall_o;

    if_fetch dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
        .im_addr(im_addr), .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
        .pc_o(pc_o), .pc4_o(pc4_o), .inst_o(inst_o), .mem_stall_o(mem_stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    logic [31:0] last_exp = 32'h0;

`ifdef IF_NOP_BUBBLE_EN
    localparam logic [31:0] RST_INST = 32'h0000_0013;
`else
    localparam logic [31:0] RST_INST = 32'h0000_0000;
`endif

    // Memory contents: address 0 holds 0x00A00093 (addi x1,x0,10).
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h00A0_0093;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mdata(pc);
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (im_req_valid && im_req_ready) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL wait_acc: got timeout expected accept"); end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] a);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (im_req_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL expect_req: got timeout expected request %h", a);
        end else chk("req_addr", im_addr, a);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (q.size() == 0) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL drain: got %0d pending expected 0", q.size()); end
    endtask

    task automatic chk_reset();
        chk("rst_req_valid", {31'h0, im_req_valid}, 32'h0);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc4_o, 32'h4);
        chk("rst_stall", {31'h0, mem_stall_o}, 32'h1);
        chk("rst_inst", inst_o, RST_INST);
    endtask

    // Memory responder: one response lat cycles after acceptance.
    initial begin
        int          cnt = 0;
        logic [31:0] paddr = 32'h0;
        bit          acc;
        im_rsp_valid = 1'b0;
        im_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            acc = im_req_valid && im_req_ready;
            if (acc) paddr = im_addr;
            #1;
            im_rsp_valid = 1'b0;
            if (acc) cnt = lat;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    im_rsp_valid = 1'b1;
                    im_rsp_data  = mdata(paddr);
                end
            end
        end
    end

    // Monitor: compare every presented instruction against the queue head; pop when consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp = 32'h0;
            end else if (mem_stall_o) begin
`ifdef IF_NOP_BUBBLE_EN
                chk("bubble_inst", inst_o, 32'h0000_0013);
`else
                chk("bubble_inst", inst_o, last_exp);
`endif
            end else if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", pc_o, inst_o);
            end else begin
                e = q[0];
                chk("pc", pc_o, e.pc);
                chk("pc4", pc4_o, e.pc + 32'd4);
                chk("inst", inst_o, e.inst);
                last_exp = e.inst;
                if (!hazard_stall || redirect) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; hazard_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        im_req_ready = 1'b1;
        step(2);
        @(negedge clk);
        chk_reset();

        // Plain fetch stream from reset.
        push(32'h0); push(32'h4); push(32'h8);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_valid", {31'h0, im_req_valid}, 32'h0);
        expect_req(32'h0);
        wait_drain();

        // Hazard stall over a response: held for 3 cycles, then consumed.
        push(32'hC); push(32'h10);
        wait_acc();
        hazard_stall = 1'b1;
        step(3);
        hazard_stall = 1'b0;
        wait_drain();

        // Redirect in WAIT, response arrives later and is dropped.
        lat = 2;
        wait_acc();
        redirect = 1'b1; redirect_pc = 32'h100;
        push(32'h100); push(32'h104);
        step(1);
        redirect = 1'b0;
        expect_req(32'h100);
        wait_drain();

        // Redirect in REQ while memory is not ready: address held, response dropped.
        lat = 1;
        im_req_ready = 1'b0;
        step(1);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("stall_addr0", im_addr, 32'h108);
        step(1);
        redirect = 1'b0;
        @(negedge clk);
        chk("stall_addr1", im_addr, 32'h108);
        chk("stall_valid1", {31'h0, im_req_valid}, 32'h1);
        step(1);
        im_req_ready = 1'b1;
        push(32'h200);
        wait_acc();
        expect_req(32'h200);
        wait_drain();

        // Redirect and hazard together in HOLD, target at the top of the address space.
        push(32'h204);
        wait_acc();
        hazard_stall = 1'b1;
        step(1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect = 1'b0; hazard_stall = 1'b0;
        push(32'hFFFF_FFFC);
        expect_req(32'hFFFF_FFFC);
        wait_drain();
        expect_req(32'h0);
        push(32'h0);
        wait_drain();

        // Reset mid-fetch: the late response must be ignored.
        lat = 3;
        wait_acc();
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset();
        step(1);
        rst = 1'b0;
        push(32'h0); push(32'h4);
        expect_req(32'h0);
        wait_drain();

        step(3);
        chk("queue_empty", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
